// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and counter-width helper.
package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter must hold values 0..n, so it needs clog2(n+1) bits.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int N = DIV_N
) ();

  logic         start;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         done;
  logic         busy;
  logic         div0;

  modport master (
    output start, X, Y,
    input  Q, R, done, busy, div0
  );

  modport slave (
    input  start, X, Y,
    output Q, R, done, busy, div0
  );

endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration: shift {A,Qr} left, trial
// subtract the divisor, keep the difference or restore.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] qr,
  input  logic [N-1:0] m,
  output logic [N:0]   a_next,
  output logic [N-1:0] qr_next
);

  logic [2*N:0] shifted;
  logic [N:0]   a_shifted;
  logic [N-1:0] qr_shifted;
  logic [N:0]   trial;

  assign shifted    = {a, qr} << 1;
  assign a_shifted  = shifted[2*N:N];
  assign qr_shifted = shifted[N-1:0];
  assign trial      = a_shifted - {1'b0, m};

  // A clear sign bit means the divisor fitted: keep the difference, quotient bit 1.
  always_comb begin
    a_next  = a_shifted;
    qr_next = qr_shifted;
    if (!trial[N]) begin
      a_next  = trial;
      qr_next = qr_shifted | {{(N-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// with a start/done handshake and a divide-by-zero shortcut.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_w(N);

  div_state_t   state_q, state_d;
  logic [N:0]   a_q, a_d;
  logic [N-1:0] qr_q, qr_d;
  logic [N-1:0] m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         div0_q, div0_d;

  logic [N:0]   step_a;
  logic [N-1:0] step_qr;

  div_step #(.N(N)) u_step (
    .a       (a_q),
    .qr      (qr_q),
    .m       (m_q),
    .a_next  (step_a),
    .qr_next (step_qr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      div0_q  <= div0_d;
    end
  end

  // DONE accepts a new request exactly like IDLE; start is ignored during CALC.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    busy_d  = busy_q;
    div0_d  = div0_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d    = '0;
          qr_d   = bus.X;
          m_d    = bus.Y;
          cnt_d  = '0;
          done_d = 1'b0;
          div0_d = 1'b0;
          if (bus.Y == '0) begin
            qr_d    = '1;
            a_d     = {1'b0, bus.X};
            div0_d  = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        a_d   = step_a;
        qr_d  = step_qr;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Q    = qr_q;
  assign bus.R    = a_q[N-1:0];
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.div0 = div0_q;

endmodule
